// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM burst reader: widths, memory depth and FSM encoding.
package eeprom_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/eeprom_reader_if.sv
// Memory read port plus valid/ready output stream of the EEPROM reader.
interface eeprom_reader_if
    import eeprom_pkg::*;
#(
    parameter int unsigned DW = eeprom_pkg::DW,
    parameter int unsigned AW = eeprom_pkg::AW
);

    logic          ld;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output ld, a, out_data, out_valid,
        input  d, out_ready
    );

    modport slave (
        input  ld, a, out_data, out_valid,
        output d, out_ready
    );

endinterface

// File: rtl/reader_fifo2.sv
// Two-entry synchronous FIFO; head shows the oldest word, storage clears on reset.
module reader_fifo2
    import eeprom_pkg::*;
#(
    parameter int unsigned DW = eeprom_pkg::DW
) (
    input  logic          c,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    logic [DW-1:0] r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == 2'd2);
    assign empty     = (r_count == 2'd0);
    assign head      = r_mem[r_rptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/eeprom_reader.sv
// Burst reader: fetches len words from base (wrapping), buffering them in a 2-deep FIFO
// toward a valid/ready sink; pulses done once the last word has left.
module eeprom_reader
    import eeprom_pkg::*;
#(
    parameter int unsigned DW = eeprom_pkg::DW,
    parameter int unsigned AW = eeprom_pkg::AW
) (
    input  logic          c,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic          ld,
    output logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int unsigned WORDS   = 2 ** AW;
    localparam logic [AW:0] MAX_LEN = (AW + 1)'(WORDS);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_rem;
    logic          r_done;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_ld;
    logic          w_busy;
    logic          w_done_set;
    logic          w_accept;
    logic [AW:0]   w_len_clamped;

    assign w_accept      = (r_state == IDLE) && start;
    assign w_len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
    assign w_pop         = !w_empty && out_ready;

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A zero-length burst parks in DRAIN for one cycle with an empty FIFO.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next_state = (len == '0) ? DRAIN : READ;
            READ:    if (w_ld && (r_rem == (AW + 1)'(1))) w_next_state = DRAIN;
            DRAIN:   if (w_empty || (w_pop && !w_full)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_ld       = 1'b0;
        w_busy     = 1'b1;
        w_done_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_busy     = 1'b0;
                w_done_set = start && (len == '0);
            end
            READ:    w_ld = (r_rem != '0) && !w_full;
            DRAIN:   w_done_set = w_pop && !w_full;
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_rem  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_accept) begin
                r_addr <= base;
                r_rem  <= w_len_clamped;
            end else if (w_ld) begin
                r_addr <= r_addr + AW'(1);
                r_rem  <= r_rem - (AW + 1)'(1);
            end
        end
    end

    reader_fifo2 #(.DW(DW)) u_fifo (
        .c     (c),
        .rst   (rst),
        .push  (w_ld),
        .pop   (w_pop),
        .din   (d),
        .full  (w_full),
        .empty (w_empty),
        .head  (out_data)
    );

    assign ld        = w_ld;
    assign a         = r_addr;
    assign out_valid = !w_empty;
    assign busy      = w_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_eeprom_reader.sv
// Directed bench for eeprom_reader: a word-queue reference model checked every cycle,
// plus literal expectations per burst scenario.
module tb_eeprom_reader;

    logic       c     = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [3:0] base  = '0;
    logic [4:0] len   = '0;
    logic       busy;
    logic       done;

    eeprom_reader_if #(.DW(32), .AW(4)) bus ();

    logic [31:0] mem [16];

    int n_chk  = 0;
    int n_fail = 0;

    // reference model and observation log, owned by the compare process
    bit          m_busy = 1'b0;
    bit          m_zero = 1'b0;
    bit          m_done = 1'b0;
    logic [3:0]  m_addr = '0;
    int          m_rem  = 0;
    logic [31:0] m_fifo [$];
    int          cyc = 0, ld_cnt = 0, done_cnt = 0, busy_cnt = 0, done_cyc = 0, start_cyc = 0;
    logic [31:0] recv [$];
    int          pop_cyc [$];
    logic [3:0]  addr_log [$];

    // scenario marks, owned by the stimulus process
    int ld0, dn0, bz0, r0, a0;
    logic [3:0] s2_addr [4] = '{4'd14, 4'd15, 4'd0, 4'd1};

    always #5 c = ~c;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
    end

    assign bus.d = mem[bus.a];

    eeprom_reader #(.DW(32), .AW(4)) dut (
        .c         (c),
        .rst       (rst),
        .start     (start),
        .base      (base),
        .len       (len),
        .ld        (bus.ld),
        .a         (bus.a),
        .d         (bus.d),
        .out_data  (bus.out_data),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rv(input int i);
        return (i < recv.size()) ? recv[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic int pc(input int i);
        return (i < pop_cyc.size()) ? pop_cyc[i] : -1000;
    endfunction

    always @(negedge c) begin
        bit exp_ld, pop, cur_busy;
        cyc++;
        if (rst) begin
            chk("rst_ld", bus.ld, 0);
            chk("rst_a", bus.a, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            m_busy = 0; m_zero = 0; m_done = 0; m_rem = 0;
            m_fifo.delete();
        end else begin
            cur_busy = m_busy;
            exp_ld   = m_busy && (m_rem != 0) && (m_fifo.size() < 2);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("ld", bus.ld, exp_ld);
            chk("out_valid", bus.out_valid, m_fifo.size() != 0);
            if (bus.out_valid && m_fifo.size() != 0) chk("out_data", bus.out_data, m_fifo[0]);
            if (bus.ld && exp_ld) chk("a", bus.a, m_addr);
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (busy) busy_cnt++;
            if (bus.ld) begin ld_cnt++; addr_log.push_back(bus.a); end
            pop = bus.out_valid && bus.out_ready;
            if (pop) begin recv.push_back(bus.out_data); pop_cyc.push_back(cyc); end

            m_done = 0;
            if (pop && m_fifo.size() != 0) void'(m_fifo.pop_front());
            if (exp_ld) begin
                m_fifo.push_back(mem[m_addr]);
                m_addr = m_addr + 4'd1;
                m_rem--;
            end
            if (m_zero) begin
                m_busy = 0; m_zero = 0;
            end else if (m_busy && m_rem == 0 && pop && m_fifo.size() == 0) begin
                m_busy = 0; m_done = 1;
            end
            if (start && !cur_busy) begin
                start_cyc = cyc;
                m_busy    = 1;
                if (len == 0) begin
                    m_zero = 1; m_done = 1;
                end else begin
                    m_addr = base;
                    m_rem  = (len > 16) ? 16 : int'(len);
                end
            end
        end
    end

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic mark();
        ld0 = ld_cnt; dn0 = done_cnt; bz0 = busy_cnt; r0 = recv.size(); a0 = addr_log.size();
    endtask

    task automatic kick(input logic [3:0] b, input logic [4:0] l);
        base = b; len = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk({name, "_idle_bound"}, n < 100, 1);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.out_ready = 1'b1;
        #1;
        chk("reset_ld", bus.ld, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_busy", busy, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // full 16-word burst, sink always ready
        mark(); kick(4'd0, 5'd16); wait_idle("s1");
        chk("s1_ld_cycles", ld_cnt - ld0, 16);
        chk("s1_words", recv.size() - r0, 16);
        for (int i = 0; i < 16; i++) chk("s1_word", rv(r0 + i), 32'hA000_0000 + i);
        chk("s1_first_latency", pc(r0) - start_cyc, 2);
        chk("s1_back_to_back", pc(r0 + 15) - pc(r0), 15);
        chk("s1_done_count", done_cnt - dn0, 1);
        chk("s1_done_after_pop", done_cyc - pc(r0 + 15), 1);

        // address wrap 15 -> 0
        mark(); kick(4'd14, 5'd4); wait_idle("s2");
        chk("s2_ld_cycles", ld_cnt - ld0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("s2_addr", (a0 + i < addr_log.size()) ? addr_log[a0 + i] : 4'hx, s2_addr[i]);
            chk("s2_word", rv(r0 + i), 32'hA000_0000 + s2_addr[i]);
        end

        // sink stalled for 10 cycles
        bus.out_ready = 1'b0;
        mark(); kick(4'd3, 5'd5);
        repeat (10) tick();
        chk("s3_ld_while_stalled", ld_cnt - ld0, 2);
        chk("s3_nothing_popped", recv.size() - r0, 0);
        bus.out_ready = 1'b1;
        wait_idle("s3");
        chk("s3_words", recv.size() - r0, 5);
        for (int i = 0; i < 5; i++) chk("s3_word", rv(r0 + i), 32'hA000_0003 + i);
        chk("s3_ld_total", ld_cnt - ld0, 5);
        chk("s3_done_count", done_cnt - dn0, 1);

        // zero-length burst
        mark(); kick(4'd7, 5'd0); wait_idle("s4");
        chk("s4_no_ld", ld_cnt - ld0, 0);
        chk("s4_busy_cycles", busy_cnt - bz0, 1);
        chk("s4_done_count", done_cnt - dn0, 1);
        chk("s4_done_latency", done_cyc - start_cyc, 1);

        // reset mid-burst
        mark(); kick(4'd0, 5'd8);
        n = 0;
        while (recv.size() - r0 < 2 && n < 50) begin tick(); n++; end
        chk("s5_reach_word2_bound", n < 50, 1);
        #2 rst = 1'b1;
        #1;
        chk("s5_ld_async", bus.ld, 0);
        chk("s5_valid_async", bus.out_valid, 0);
        chk("s5_busy_async", busy, 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("s5_no_done", done_cnt - dn0, 0);
        mark(); kick(4'd0, 5'd1); wait_idle("s5b");
        chk("s5_after_reset_words", recv.size() - r0, 1);
        chk("s5_after_reset_word", rv(r0), 32'hA000_0000);

        // len clamp plus a start while busy
        mark(); kick(4'd0, 5'd20);
        repeat (3) tick();
        kick(4'd5, 5'd3);
        wait_idle("s6");
        chk("s6_words", recv.size() - r0, 16);
        for (int i = 0; i < 16; i++) chk("s6_word", rv(r0 + i), 32'hA000_0000 + i);
        chk("s6_ld_cycles", ld_cnt - ld0, 16);
        chk("s6_done_count", done_cnt - dn0, 1);

        // start held through the end of a burst is taken only once back in IDLE
        mark(); kick(4'd9, 5'd1);
        base = 4'd2; len = 5'd1; start = 1'b1;
        n = 0;
        while (busy && n < 50) begin tick(); n++; end
        chk("s7_idle_bound", n < 50, 1);
        tick();
        start = 1'b0;
        wait_idle("s7");
        chk("s7_words", recv.size() - r0, 2);
        chk("s7_word0", rv(r0), 32'hA000_0009);
        chk("s7_word1", rv(r0 + 1), 32'hA000_0002);
        chk("s7_done_count", done_cnt - dn0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
